sar_search16: RTL and testbench

Successive-approximation search engine that drives the B operand of the team's 16-bit magnitude comparator and consumes its equal/greater/less flags to recover the hidden A operand MSB-first. It is the initiator side of the comparator interface. It is used for threshold discovery, calibration sweeps and self-test of the comparator path. One search returns the target value in at most WIDTH decisions, with early exit on equality and a fault flag for inconsistent comparator outputs.

---
 rtl/sar_search16.sv | 154 +++++++++++++++
 tb/tb_sar_search16.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sar_search16.sv
// sar_search16 -- successive-approximation search engine driving the B operand
// of a magnitude comparator and recovering the hidden A operand MSB-first.
//
// Parameters:
//   WIDTH   : operand / probe / result width
//   CMP_LAT : settle cycles after each probe update before flags are sampled
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   start                : begin a search (sampled only in IDLE)
//   probe                : registered value driven to comparator B input
//   cmp_eq/cmp_gt/cmp_lt : comparator flags (target ==, >, < probe)
//   busy                 : search in progress
//   done                 : one-cycle completion pulse
//   result               : recovered target, held until next start
//   steps                : decisions taken in the last search
//   error                : last search aborted on non-one-hot flags
module sar_search16 #(
   parameter int WIDTH   = 16,
   parameter int CMP_LAT = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic [WIDTH-1:0]       probe,
   input  logic                   cmp_eq,
   input  logic                   cmp_gt,
   input  logic                   cmp_lt,
   output logic                   busy,
   output logic                   done,
   output logic [WIDTH-1:0]       result,
   output logic [$clog2(WIDTH):0] steps,
   output logic                   error
);

   localparam int BW = $clog2(WIDTH);
   localparam int CW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((CMP_LAT > 0) ? (CMP_LAT - 1) : 0);
   localparam bit HAS_SETTLE = (CMP_LAT > 0);

   typedef enum logic [1:0] {IDLE, SETTLE, DECIDE, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] accum, accum_nxt, probe_nxt;
   logic [BW-1:0]    bit_idx, bit_nxt;
   logic [CW-1:0]    settle_cnt;
   logic             flags_ok;
   logic             last_bit;

   // Decision datapath: candidate accumulator and next trial probe
   always_comb begin
      flags_ok  = ({cmp_eq, cmp_gt, cmp_lt} == 3'b100) ||
                  ({cmp_eq, cmp_gt, cmp_lt} == 3'b010) ||
                  ({cmp_eq, cmp_gt, cmp_lt} == 3'b001);
      accum_nxt = cmp_gt ? probe : accum;
      bit_nxt   = bit_idx - 1'b1;
      probe_nxt = accum_nxt | (WIDTH'(1) << bit_nxt);
      last_bit  = (bit_idx == '0);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = HAS_SETTLE ? SETTLE : DECIDE;
            end
         end
         SETTLE: begin
            if (settle_cnt == CNT_LAST) begin
               state_nxt = DECIDE;
            end
         end
         DECIDE: begin
            if (!flags_ok || cmp_eq || last_bit) begin
               state_nxt = DONE;
            end else begin
               state_nxt = HAS_SETTLE ? SETTLE : DECIDE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output decode
   always_comb begin
      busy = (state == SETTLE) || (state == DECIDE);
      done = (state == DONE);
   end

   // Search datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         probe      <= '0;
         accum      <= '0;
         bit_idx    <= '0;
         settle_cnt <= '0;
         result     <= '0;
         steps      <= '0;
         error      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  accum      <= '0;
                  result     <= '0;
                  steps      <= '0;
                  error      <= 1'b0;
                  bit_idx    <= BW'(WIDTH - 1);
                  probe      <= {1'b1, {(WIDTH-1){1'b0}}};
                  settle_cnt <= '0;
               end
            end
            SETTLE: begin
               settle_cnt <= (settle_cnt == CNT_LAST) ? '0 : settle_cnt + 1'b1;
            end
            DECIDE: begin
               steps <= steps + 1'b1;
               if (!flags_ok) begin
                  error  <= 1'b1;
                  result <= accum;
               end else if (cmp_eq) begin
                  result <= probe;
               end else begin
                  accum <= accum_nxt;
                  if (last_bit) begin
                     result <= accum_nxt;
                  end else begin
                     bit_idx <= bit_nxt;
                     probe   <= probe_nxt;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sar_search16.sv
// tb_sar_search16 -- self-checking bench for sar_search16.
// Two instances (CMP_LAT=0 and CMP_LAT=2) share a behavioural comparator
// model; sel chooses which one is exercised. Expected results come from the
// binary-search properties of the target value, not from the engine's state.
module tb_sar_search16;

   logic        clk = 1'b0;
   logic        rst_n, start, sel;
   logic        cmp_eq, cmp_gt, cmp_lt;
   logic        start0, start1;
   logic [15:0] probe0, probe1, result0, result1;
   logic [4:0]  steps0, steps1;
   logic        busy0, busy1, done0, done1, error0, error1;

   logic [15:0] probe_m, result_m;
   logic [4:0]  steps_m;
   logic        busy_m, done_m, error_m;

   logic [15:0] target;
   logic        fault_active, glitch_active;
   logic [2:0]  fault_pat, glitch_pat;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign start0 = start & ~sel;
   assign start1 = start & sel;

   sar_search16 #(.WIDTH(16), .CMP_LAT(0)) u_lat0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .probe(probe0),
      .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
      .busy(busy0), .done(done0), .result(result0), .steps(steps0), .error(error0)
   );

   sar_search16 #(.WIDTH(16), .CMP_LAT(2)) u_lat2 (
      .clk(clk), .rst_n(rst_n), .start(start1), .probe(probe1),
      .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
      .busy(busy1), .done(done1), .result(result1), .steps(steps1), .error(error1)
   );

   assign probe_m  = sel ? probe1  : probe0;
   assign result_m = sel ? result1 : result0;
   assign steps_m  = sel ? steps1  : steps0;
   assign busy_m   = sel ? busy1   : busy0;
   assign done_m   = sel ? done1   : done0;
   assign error_m  = sel ? error1  : error0;

   // Behavioural comparator with fault and glitch injection
   always_comb begin
      {cmp_eq, cmp_gt, cmp_lt} = 3'b000;
      if (fault_active) begin
         {cmp_eq, cmp_gt, cmp_lt} = fault_pat;
      end else if (glitch_active) begin
         {cmp_eq, cmp_gt, cmp_lt} = glitch_pat;
      end else begin
         cmp_eq = (target == probe_m);
         cmp_gt = (target >  probe_m);
         cmp_lt = (target <  probe_m);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Search ends when the trial bit reaches the lowest set bit of the target
   function automatic int nat_steps(input logic [15:0] t);
      for (int i = 0; i < 16; i++) begin
         if (t[i]) return 16 - i;
      end
      return 16;
   endfunction

   // Probe for decision k: target bits above the trial bit, plus the trial bit
   function automatic logic [15:0] probe_at(input logic [15:0] t, input int k);
      logic [31:0] up;
      logic [15:0] one;
      up  = 32'hFFFF << (17 - k);
      one = 16'h1;
      return (t & up[15:0]) | (one << (16 - k));
   endfunction

   task automatic run_search(input logic s, input logic [15:0] t, input int f,
                             input logic [2:0] fpat, input bit glitch, input bit poke);
      int          per, ns, exp_steps, done_c, budget;
      logic [15:0] exp_res;
      logic        exp_err;
      logic [31:0] up;
      per = s ? 3 : 1;
      ns  = nat_steps(t);
      if (f > 0 && f <= ns) begin
         exp_steps = f;
         exp_err   = 1'b1;
         up        = 32'hFFFF << (17 - f);
         exp_res   = t & up[15:0];
      end else begin
         exp_steps = ns;
         exp_err   = 1'b0;
         exp_res   = t;
      end

      @(negedge clk);
      sel       = s;
      target    = t;
      fault_pat = fpat;
      start     = 1'b1;
      @(posedge clk);
      done_c = -1;
      budget = 16 * per + 4;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         start         = poke && (c == 2);
         fault_active  = (f > 0) && (c == f * per);
         glitch_active = glitch && ((c % per) != 0);
         glitch_pat    = 3'($urandom);
         if ((c % per) == 0 && (c / per) <= exp_steps)
            check_eq("probe", 32'(probe_m), 32'(probe_at(t, c / per)));
         if (c == 1) check_eq("busy_run", 32'(busy_m), 32'd1);
         @(posedge clk);
         #1;
         if (done_m) begin
            done_c = c;
            break;
         end
      end
      fault_active  = 1'b0;
      glitch_active = 1'b0;
      start         = 1'b0;
      check_eq("done_cycle", 32'(done_c), 32'(exp_steps * per));
      check_eq("result", 32'(result_m), 32'(exp_res));
      check_eq("steps", 32'(steps_m), 32'(exp_steps));
      check_eq("error", 32'(error_m), 32'(exp_err));
      check_eq("busy_done", 32'(busy_m), 32'd0);

      // start during the done cycle must be ignored
      @(negedge clk);
      start = poke;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq("done_pulse", 32'(done_m), 32'd0);
      check_eq("busy_idle", 32'(busy_m), 32'd0);
      check_eq("result_hold", 32'(result_m), 32'(exp_res));
   endtask

   logic [2:0] bad_pats [5] = '{3'b000, 3'b110, 3'b101, 3'b011, 3'b111};

   initial begin
      int pulses;
      rst_n = 1'b0; start = 1'b0; sel = 1'b0; target = '0;
      fault_active = 1'b0; glitch_active = 1'b0; fault_pat = '0; glitch_pat = '0;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_probe", 32'({probe0, probe1}), 32'd0);
      check_eq("rst_result", 32'({result0, result1}), 32'd0);
      check_eq("rst_steps", 32'({steps0, steps1}), 32'd0);
      check_eq("rst_flags", 32'({busy0, busy1, done0, done1, error0, error1}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_search(1'b0, 16'h0000, 0, 3'b000, 1'b0, 1'b1);
      run_search(1'b0, 16'h8000, 0, 3'b000, 1'b0, 1'b0);
      run_search(1'b0, 16'hFFFF, 0, 3'b000, 1'b0, 1'b1);
      run_search(1'b1, 16'h1234, 0, 3'b000, 1'b1, 1'b1);
      run_search(1'b0, 16'hA5A5, 3, 3'b110, 1'b0, 1'b0);
      run_search(1'b1, 16'h0001, 16, 3'b000, 1'b1, 1'b0);

      // reset in the middle of a search: abort without done
      @(negedge clk);
      sel = 1'b0; target = 16'h00FF; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("busy_pre_rst", 32'(busy_m), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_eq("mid_rst_probe", 32'(probe_m), 32'd0);
      check_eq("mid_rst_result", 32'(result_m), 32'd0);
      check_eq("mid_rst_steps", 32'(steps_m), 32'd0);
      check_eq("mid_rst_flags", 32'({busy_m, done_m, error_m}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done_m) pulses++;
      end
      check_eq("no_done_after_rst", 32'(pulses), 32'd0);
      run_search(1'b0, 16'h00FF, 0, 3'b000, 1'b0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         logic        s;
         logic [15:0] t;
         int          f;
         s = 1'($urandom_range(0, 1));
         t = 16'($urandom);
         f = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 0;
         run_search(s, t, f, bad_pats[$urandom_range(0, 4)], s, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
